rate_decoder: RTL

- Decodes the switch-selected rate setting from a stream of valid ticks, such as the ticks the rate counter sends to the shift register.
- Measures the cycle interval between tick rising edges and matches it against the shared rate table.
- Reports the recovered 2-bit rate code after two consecutive intervals agree.
- Used for on-board self-check of the counter and as a rate-sensing front end for consumer blocks.

---
 rtl/rate_decoder_pkg.sv | 32 +++
 rtl/rate_decoder_if.sv | 33 +++
 rtl/rate_decoder_interval_meter.sv | 45 ++++
 rtl/rate_decoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rate_decoder_pkg.sv
// rate_decoder_pkg: shared rate table defaults, rate code width and FSM states.
// Also used by the rate counter so both ends agree on tick periods.
package rate_decoder_pkg;

    localparam int              RATE_W         = 2;
    localparam int              ERR_W          = 8;
    localparam int              NB_COUNTER_DEF = 32;
    localparam longint unsigned LIMIT_0_DEF    = 64'd8388608;
    localparam longint unsigned LIMIT_1_DEF    = 64'd16777216;
    localparam longint unsigned LIMIT_2_DEF    = 64'd33554432;
    localparam longint unsigned LIMIT_3_DEF    = 64'd67108864;
    localparam longint unsigned TOL_DEF        = 64'd2;

    typedef logic [RATE_W-1:0] rate_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEASURE   = 2'd1,
        CANDIDATE = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    // True when v lies within lim +/- tol, inclusive.
    function automatic logic in_win(
        input longint unsigned v,
        input longint unsigned lim,
        input longint unsigned tol
    );
        return (v + tol >= lim) && (v <= lim + tol);
    endfunction

endpackage

// File: rtl/rate_decoder_if.sv
// rate_decoder_if: tick input and decoded rate outputs of the rate decoder.
// RATE_DECODER_ERR_CNT_EN adds the o_err_count signal.
interface rate_decoder_if;
    import rate_decoder_pkg::*;

    logic  i_valid;
    rate_t o_rate;
    logic  o_locked;
    logic  o_update;

`ifdef RATE_DECODER_ERR_CNT_EN
    logic [ERR_W-1:0] o_err_count;

    modport master (
        output i_valid,
        input  o_rate, o_locked, o_update, o_err_count
    );
    modport slave (
        input  i_valid,
        output o_rate, o_locked, o_update, o_err_count
    );
`else
    modport master (
        output i_valid,
        input  o_rate, o_locked, o_update
    );
    modport slave (
        input  i_valid,
        output o_rate, o_locked, o_update
    );
`endif

endinterface

// File: rtl/rate_decoder_interval_meter.sv
// rate_decoder_interval_meter: rising-edge detector plus saturating interval
// counter; reports the cycle count between edges and a silence timeout.
module rate_decoder_interval_meter #(
    parameter int              NB_COUNTER = 32,
    parameter longint unsigned TMO        = 64'd67108866
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  valid_i,
    output logic                  edge_o,
    output logic [NB_COUNTER-1:0] interval_o,
    output logic                  timeout_o
);

    localparam logic [NB_COUNTER-1:0] ONE = {{(NB_COUNTER-1){1'b0}}, 1'b1};

    logic                  valid_q;
    logic [NB_COUNTER-1:0] cnt_q;
    logic [NB_COUNTER-1:0] cnt_d;

    assign edge_o     = valid_i & ~valid_q;
    assign interval_o = cnt_q;
    assign timeout_o  = ~edge_o & (64'(cnt_q) > TMO);

    // Restart at 1 on an edge so an edge L cycles later samples L.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_o)
            cnt_d = ONE;
        else if (cnt_q != '1)
            cnt_d = cnt_q + ONE;
    end

    // Edge-detect history and interval counter.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_i;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rate_decoder.sv
// rate_decoder: matches tick intervals against the rate table and locks once
// two consecutive intervals agree. Option: RATE_DECODER_ERR_CNT_EN.
module rate_decoder
    import rate_decoder_pkg::*;
#(
    parameter int              NB_COUNTER = NB_COUNTER_DEF,
    parameter longint unsigned LIMIT_0    = LIMIT_0_DEF,
    parameter longint unsigned LIMIT_1    = LIMIT_1_DEF,
    parameter longint unsigned LIMIT_2    = LIMIT_2_DEF,
    parameter longint unsigned LIMIT_3    = LIMIT_3_DEF,
    parameter longint unsigned TOL        = TOL_DEF
) (
    input logic           clock,
    input logic           i_reset,
    rate_decoder_if.slave rd
);

    logic                  edge_w;
    logic                  timeout_w;
    logic [NB_COUNTER-1:0] interval_w;

    rate_decoder_interval_meter #(
        .NB_COUNTER (NB_COUNTER),
        .TMO        (LIMIT_3 + TOL)
    ) u_meter (
        .clock      (clock),
        .i_reset    (i_reset),
        .valid_i    (rd.i_valid),
        .edge_o     (edge_w),
        .interval_o (interval_w),
        .timeout_o  (timeout_w)
    );

    logic            hit;
    rate_t           code;
    longint unsigned ival;

    // Windows are disjoint, so at most one code can match.
    always_comb begin
        ival = 64'(interval_w);
        hit  = 1'b1;
        code = '0;
        unique case (1'b1)
            in_win(ival, LIMIT_0, TOL): code = 2'd0;
            in_win(ival, LIMIT_1, TOL): code = 2'd1;
            in_win(ival, LIMIT_2, TOL): code = 2'd2;
            in_win(ival, LIMIT_3, TOL): code = 2'd3;
            default:                    hit  = 1'b0;
        endcase
    end

    state_t state_q, state_d;
    rate_t  cand_q, cand_d;
    rate_t  rate_q, rate_d;
    logic   locked_q, locked_d;
    logic   update_q, update_d;

    // Next state; an edge always wins over a simultaneous timeout.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        rate_d   = rate_q;
        locked_d = locked_q;
        update_d = 1'b0;
        if (edge_w) begin
            unique case (state_q)
                IDLE: state_d = MEASURE;
                MEASURE: begin
                    if (hit) begin
                        cand_d  = code;
                        state_d = CANDIDATE;
                    end
                end
                CANDIDATE: begin
                    if (!hit) begin
                        state_d = MEASURE;
                    end else if (code == cand_q) begin
                        state_d  = LOCKED;
                        rate_d   = code;
                        locked_d = 1'b1;
                        update_d = 1'b1;
                    end else begin
                        cand_d = code;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        state_d  = MEASURE;
                        locked_d = 1'b0;
                    end else if (code != rate_q) begin
                        cand_d   = code;
                        state_d  = CANDIDATE;
                        locked_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_w) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            rate_q   <= '0;
            locked_q <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            rate_q   <= rate_d;
            locked_q <= locked_d;
            update_q <= update_d;
        end
    end

    assign rd.o_rate   = rate_q;
    assign rd.o_locked = locked_q;
    assign rd.o_update = update_q;

`ifdef RATE_DECODER_ERR_CNT_EN
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    logic             err_hit;

    assign err_hit = (state_q == LOCKED) && (edge_w ? !hit : timeout_w);
    assign err_d   = (err_hit && err_q != '1) ? err_q + ERR_W'(1) : err_q;

    // Count locks lost to bad intervals or silence; cleared only by reset.
    always_ff @(posedge clock) begin
        if (i_reset)
            err_q <= '0;
        else
            err_q <= err_d;
    end

    assign rd.o_err_count = err_q;
`endif

endmodule
